// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Request ports, memory command port and perf counters of the
//            two-port memory arbiter. slave = arbiter view, master = environment.
// Revision : 1.0
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              p0_cmd_start, p0_cmd_write, p0_cmd_ready;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata, p0_wmask, p0_rdata;
  logic              p0_rdata_valid;

  logic              p1_cmd_start, p1_cmd_write, p1_cmd_ready;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata, p1_wmask, p1_rdata;
  logic              p1_rdata_valid;

  logic              mem_cmd_start, mem_cmd_write, mem_cmd_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_wmask, mem_rdata;
  logic              mem_rdata_valid;

  logic [31:0]       perf_grant0, perf_grant1, perf_stall;

  modport slave (
    input  p0_cmd_start, p0_cmd_write, p0_addr, p0_wdata, p0_wmask,
    output p0_cmd_ready, p0_rdata, p0_rdata_valid,
    input  p1_cmd_start, p1_cmd_write, p1_addr, p1_wdata, p1_wmask,
    output p1_cmd_ready, p1_rdata, p1_rdata_valid,
    output mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata, mem_wmask,
    input  mem_cmd_ready, mem_rdata, mem_rdata_valid,
    output perf_grant0, perf_grant1, perf_stall
  );

  modport master (
    output p0_cmd_start, p0_cmd_write, p0_addr, p0_wdata, p0_wmask,
    input  p0_cmd_ready, p0_rdata, p0_rdata_valid,
    output p1_cmd_start, p1_cmd_write, p1_addr, p1_wdata, p1_wmask,
    input  p1_cmd_ready, p1_rdata, p1_rdata_valid,
    input  mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata, mem_wmask,
    output mem_cmd_ready, mem_rdata, mem_rdata_valid,
    input  perf_grant0, perf_grant1, perf_stall
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory command port between fetch (port 0, priority)
//            and load/store (port 1, aged). Perf counters: MEM_ARB_PERF_COUNTERS_EN.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int                  c_wait_w   = 4;
  localparam logic [c_wait_w-1:0] c_max_wait = c_wait_w'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WAIT_READ = 2'b01
  } state_t;

  state_t                 r_state, w_state_nxt;

  logic [1:0]             w_req_start, w_req_write;
  logic [1:0][ADDR_W-1:0] w_req_addr;
  logic [1:0][DATA_W-1:0] w_req_wdata, w_req_wmask;

  logic [1:0]             r_slot_valid, r_slot_write;
  logic [1:0][ADDR_W-1:0] r_slot_addr;
  logic [1:0][DATA_W-1:0] r_slot_wdata, r_slot_wmask;

  logic [1:0]             w_grant;
  logic                   w_gsel;
  logic                   w_issue_read;
  logic                   w_read_done;
  logic                   r_owner;
  logic [ADDR_W-1:0]      r_issue_addr;
  logic [c_wait_w-1:0]    r_wait_cnt;
  logic [1:0]             r_rdata_valid;
  logic [1:0][DATA_W-1:0] r_rdata;

  assign w_req_start = {bus.p1_cmd_start, bus.p0_cmd_start};
  assign w_req_write = {bus.p1_cmd_write, bus.p0_cmd_write};
  assign w_req_addr  = {bus.p1_addr,      bus.p0_addr};
  assign w_req_wdata = {bus.p1_wdata,     bus.p0_wdata};
  assign w_req_wmask = {bus.p1_wmask,     bus.p0_wmask};

  assign bus.p0_cmd_ready   = ~r_slot_valid[0];
  assign bus.p1_cmd_ready   = ~r_slot_valid[1];
  assign bus.p0_rdata       = r_rdata[0];
  assign bus.p1_rdata       = r_rdata[1];
  assign bus.p0_rdata_valid = r_rdata_valid[0];
  assign bus.p1_rdata_valid = r_rdata_valid[1];

  // A slot can only be granted while full, and only captures while empty,
  // so refill after a grant always lands on the following cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        r_slot_valid[i] <= 1'b0;
        r_slot_write[i] <= 1'b0;
        r_slot_addr[i]  <= '0;
        r_slot_wdata[i] <= '0;
        r_slot_wmask[i] <= '0;
      end else if (w_req_start[i] && !r_slot_valid[i]) begin
        r_slot_valid[i] <= 1'b1;
        r_slot_write[i] <= w_req_write[i];
        r_slot_addr[i]  <= w_req_addr[i];
        r_slot_wdata[i] <= w_req_wdata[i];
        r_slot_wmask[i] <= w_req_wmask[i];
      end else if (w_grant[i]) begin
        r_slot_valid[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    w_grant = 2'b00;
    if (r_state == ST_IDLE && bus.mem_cmd_ready) begin
      if (r_slot_valid[1] && (!r_slot_valid[0] || r_wait_cnt == c_max_wait))
        w_grant = 2'b10;
      else if (r_slot_valid[0])
        w_grant = 2'b01;
    end
  end

  assign w_gsel       = w_grant[1];
  assign w_issue_read = (|w_grant) && !r_slot_write[w_gsel];
  assign w_read_done  = (r_state == ST_WAIT_READ) && bus.mem_rdata_valid;

  always_comb begin
    w_state_nxt       = r_state;
    bus.mem_cmd_start = 1'b0;
    bus.mem_cmd_write = 1'b0;
    bus.mem_addr      = '1;
    bus.mem_wdata     = '1;
    bus.mem_wmask     = '1;
    case (r_state)
      ST_IDLE: begin
        if (|w_grant) begin
          bus.mem_cmd_start = 1'b1;
          bus.mem_cmd_write = r_slot_write[w_gsel];
          bus.mem_addr      = r_slot_addr[w_gsel];
          bus.mem_wdata     = r_slot_wdata[w_gsel];
          bus.mem_wmask     = r_slot_wmask[w_gsel];
          if (w_issue_read)
            w_state_nxt = ST_WAIT_READ;
        end
      end
      ST_WAIT_READ: begin
        bus.mem_addr = r_issue_addr;
        if (bus.mem_rdata_valid)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_issue_addr <= '1;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue_read) begin
        r_owner      <= w_gsel;
        r_issue_addr <= r_slot_addr[w_gsel];
      end
    end
  end

  // Counts arbitrations port 1 has lost while it had a request pending.
  always_ff @(posedge clk) begin
    if (reset || !r_slot_valid[1] || w_grant[1])
      r_wait_cnt <= '0;
    else if (w_grant[0] && r_wait_cnt != c_max_wait)
      r_wait_cnt <= r_wait_cnt + c_wait_w'(1);
  end

  always_ff @(posedge clk) begin
    r_rdata_valid <= 2'b00;
    if (reset) begin
      r_rdata <= '0;
    end else if (w_read_done) begin
      r_rdata[r_owner]       <= bus.mem_rdata;
      r_rdata_valid[r_owner] <= 1'b1;
    end
  end

`ifdef MEM_ARB_PERF_COUNTERS_EN
  logic [31:0] r_perf_grant0, r_perf_grant1, r_perf_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_grant0 <= '0;
      r_perf_grant1 <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_grant[0])
        r_perf_grant0 <= r_perf_grant0 + 32'd1;
      if (w_grant[1])
        r_perf_grant1 <= r_perf_grant1 + 32'd1;
      if (r_state == ST_IDLE && (|r_slot_valid) && !bus.mem_cmd_ready)
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign bus.perf_grant0 = r_perf_grant0;
  assign bus.perf_grant1 = r_perf_grant1;
  assign bus.perf_stall  = r_perf_stall;
`else
  assign bus.perf_grant0 = '0;
  assign bus.perf_grant1 = '0;
  assign bus.perf_stall  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed + random bench for mem_port_arbiter against a
//            transaction-level reference model (pending requests, aging count).
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass = 0, n_fail = 0, n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Stimulus owned by the bench
  bit          in_start [2];
  bit          in_write [2];
  logic [31:0] in_addr [2], in_wdata [2], in_wmask [2];
  bit          m_ready, m_rv;
  logic [31:0] m_rdata;

  // Reference model: pending request per port, outstanding read, aging
  typedef struct { bit v; bit w; logic [31:0] a, d, m; } req_t;
  req_t        pend [2];
  bit          busy;
  int          owner, losses, win;
  logic [31:0] held_addr;
  logic [31:0] rd [2];
  bit          rv [2];
  logic [31:0] pg [2];
  logic [31:0] pstall;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pend[i] = '{0, 0, 0, 0, 0};
      rd[i] = 0; rv[i] = 0; pg[i] = 0;
    end
    busy = 0; owner = 0; losses = 0; win = -1; held_addr = ONES; pstall = 0;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      in_start[i] = 0; in_write[i] = 0;
      in_addr[i] = 0; in_wdata[i] = 0; in_wmask[i] = 0;
    end
    m_ready = 1; m_rv = 0; m_rdata = 0;
  endtask

  task automatic apply();
    bus.p0_cmd_start = in_start[0]; bus.p0_cmd_write = in_write[0];
    bus.p0_addr = in_addr[0]; bus.p0_wdata = in_wdata[0]; bus.p0_wmask = in_wmask[0];
    bus.p1_cmd_start = in_start[1]; bus.p1_cmd_write = in_write[1];
    bus.p1_addr = in_addr[1]; bus.p1_wdata = in_wdata[1]; bus.p1_wmask = in_wmask[1];
    bus.mem_cmd_ready = m_ready; bus.mem_rdata_valid = m_rv; bus.mem_rdata = m_rdata;
  endtask

  // One clock: drive, compare against the model, advance the model.
  task automatic tick();
    bit stall;
    apply();
    #1;
    win = -1;
    if (!busy && m_ready) begin
      if (pend[1].v && (!pend[0].v || losses >= MAX_WAIT)) win = 1;
      else if (pend[0].v) win = 0;
    end
    chk("p0_ready", bus.p0_cmd_ready, !pend[0].v);
    chk("p1_ready", bus.p1_cmd_ready, !pend[1].v);
    chk("mem_start", bus.mem_cmd_start, win >= 0);
    chk("mem_write", bus.mem_cmd_write, win >= 0 ? pend[win].w : 1'b0);
    chk("mem_addr", bus.mem_addr, win >= 0 ? pend[win].a : (busy ? held_addr : ONES));
    chk("mem_wdata", bus.mem_wdata, win >= 0 ? pend[win].d : ONES);
    chk("mem_wmask", bus.mem_wmask, win >= 0 ? pend[win].m : ONES);
    chk("p0_rdata", bus.p0_rdata, rd[0]);
    chk("p1_rdata", bus.p1_rdata, rd[1]);
    chk("p0_rvalid", bus.p0_rdata_valid, rv[0]);
    chk("p1_rvalid", bus.p1_rdata_valid, rv[1]);
`ifdef MEM_ARB_PERF_COUNTERS_EN
    chk("perf_grant0", bus.perf_grant0, pg[0]);
    chk("perf_grant1", bus.perf_grant1, pg[1]);
    chk("perf_stall", bus.perf_stall, pstall);
`else
    chk("perf_off", bus.perf_grant0 | bus.perf_grant1 | bus.perf_stall, 32'd0);
`endif
    stall = !busy && !m_ready && (pend[0].v || pend[1].v);
    rv[0] = 0; rv[1] = 0;
    if (busy && m_rv) begin
      rd[owner] = m_rdata; rv[owner] = 1; busy = 0;
    end else if (win >= 0 && !pend[win].w) begin
      busy = 1; owner = win; held_addr = pend[win].a;
    end
    if (!pend[1].v || win == 1) losses = 0;
    else if (win == 0 && losses < MAX_WAIT) losses++;
    if (win >= 0) pg[win]++;
    if (stall) pstall++;
    for (int i = 0; i < 2; i++) begin
      if (in_start[i] && !pend[i].v)
        pend[i] = '{1, in_write[i], in_addr[i], in_wdata[i], in_wmask[i]};
      else if (win == i)
        pend[i].v = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1;
    clear_inputs();
    apply();
    repeat (n) @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  task automatic set_req(input int p, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] m);
    in_start[p] = 1; in_write[p] = w; in_addr[p] = a; in_wdata[p] = d; in_wmask[p] = m;
  endtask

  // Idle ticks with a memory that answers reads after a random delay.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      m_rv    = busy && ($urandom_range(0, 2) == 0);
      m_rdata = $urandom;
      tick();
    end
    m_rv = 0;
  endtask

  initial begin
    int count, found, issues;
    @(negedge clk);
    do_reset(2);

    // Reset state
    #1;
    chk("rst_mem_addr", bus.mem_addr, ONES);
    chk("rst_p0_ready", bus.p0_cmd_ready, 1);
    tick();

    // Single read: p0 0x100, data returned three cycles after issue
    set_req(0, 0, 32'h100, 0, 0);
    tick();
    in_start[0] = 0;
    tick();
    tick(); tick();
    m_rv = 1; m_rdata = 32'hDEAD_BEEF;
    tick();
    m_rv = 0;
    #1;
    chk("single_rdata", bus.p0_rdata, 32'hDEAD_BEEF);
    chk("single_rvalid", bus.p0_rdata_valid, 1);
    tick();
    tick();

    // Simultaneous: p0 read wins, p1 write waits for the read to finish
    set_req(0, 0, 32'h0, 0, 0);
    set_req(1, 1, 32'h200, 32'h1234_5678, ONES);
    tick();
    in_start[0] = 0; in_start[1] = 0;
    tick();
    tick();
    m_rv = 1; m_rdata = 32'hA5A5_0001;
    tick();
    m_rv = 0;
    tick();
    tick();
    #1;
    chk("simul_p1_ready", bus.p1_cmd_ready, 1);

    // Starvation: p0 reads continuously, p1 read must win on 5th arbitration
    set_req(0, 0, 32'h400, 0, 0);
    set_req(1, 0, 32'h300, 0, 0);
    tick();
    in_start[1] = 0;
    count = 0; found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      m_rv = busy; m_rdata = $urandom;
      in_addr[0] = 32'h400 + 4 * k;
      tick();
      if (win == 0) count++;
      if (win == 1) found = 1;
    end
    chk("starve_granted", found, 1);
    chk("starve_losses", count, MAX_WAIT);
    in_start[0] = 0;
    run(12);

    // Backpressure: six cycles of mem_cmd_ready low with p0 pending
    do_reset(1);
    set_req(0, 0, 32'h80, 0, 0);
    m_ready = 0;
    tick();
    in_start[0] = 0;
    repeat (6) tick();
    #1;
    chk("bp_start_low", bus.mem_cmd_start, 0);
`ifdef MEM_ARB_PERF_COUNTERS_EN
    chk("bp_perf_stall", bus.perf_stall, 32'd6);
`endif
    m_ready = 1;
    tick();
    run(10);

    // Write-after-write on p1
    set_req(1, 1, 32'h10, 32'h1111_1111, ONES);
    tick();
    in_addr[1] = 32'h14; in_wdata[1] = 32'h2222_2222;
    issues = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) in_start[1] = 0;
      tick();
      if (win == 1) issues++;
    end
    chk("waw_issues", issues, 2);
    run(3);

    // Reset while a read is outstanding, stray response afterwards
    set_req(0, 0, 32'h500, 0, 0);
    tick();
    in_start[0] = 0;
    tick();
    do_reset(1);
    m_ready = 0; m_rv = 1; m_rdata = 32'hBAD0_BAD0;
    tick();
    m_rv = 0;
    tick();
    #1;
    chk("rst_rd_p0_rdata", bus.p0_rdata, 0);
    chk("rst_rd_p0_rvalid", bus.p0_rdata_valid, 0);
    chk("rst_rd_ready", {bus.p0_cmd_ready, bus.p1_cmd_ready}, 2'b11);
    m_ready = 1;
    tick();

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      for (int p = 0; p < 2; p++) begin
        in_start[p] = $urandom_range(0, 1);
        in_write[p] = $urandom_range(0, 1);
        in_addr[p]  = $urandom;
        in_wdata[p] = $urandom;
        in_wmask[p] = $urandom;
      end
      m_ready = ($urandom_range(0, 3) != 0);
      m_rv    = busy && ($urandom_range(0, 2) == 0);
      m_rdata = $urandom;
      tick();
    end
    clear_inputs();
    run(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
